pcie_dllp_rx: RTL and testbench
===============================

Name: pcie_dllp_rx

Overview:
- Receive-side DLLP decoder for the PCIe data link layer.
- Accepts 6-byte DLLPs as an 8-bit AXI-stream from the physical-layer deframer and checks length, type and (optionally) CRC.
- Emits single-cycle Ack/Nak and flow-control events to the replay and credit logic.
- Tracks InitFC1/InitFC2 reception for the DL_Init state machine.

Parameters:
- INIT_VC, 0: VC ID whose FC DLLPs drive the init tracking flags.
- FC_HDR_W, 8: width of reported HdrFC.
- FC_DATA_W, 12: width of reported DataFC.

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  DLLP byte; byte0 (type) first, byte5 last
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted
- s_axis_tlast  in  1  last byte of DLLP
- link_up_i  in  1  DL_Up/DL_Active; low clears init flags
- ack_valid_o  out  1  Ack/Nak decoded (pulse)
- ack_nak_o  out  1  0=Ack, 1=Nak
- ack_seq_o  out  12  AckNak_Seq_Num = {byte2[3:0], byte3}
- fc_valid_o  out  1  FC DLLP decoded (pulse)
- fc_phase_o  out  2  0=InitFC1, 1=InitFC2, 2=UpdateFC
- fc_class_o  out  2  0=P, 1=NP, 2=Cpl
- fc_vc_o  out  3  type[2:0]
- fc_hdr_o  out  FC_HDR_W  {byte1[5:0], byte2[7:6]}
- fc_data_o  out  FC_DATA_W  {byte2[3:0], byte3}
- misc_valid_o  out  1  PM/vendor DLLP (pulse)
- misc_dllp_o  out  32  bytes3..0 as {b3,b2,b1,b0}
- init_fc1_done_o  out  1  InitFC1 P, NP and Cpl seen on INIT_VC
- init_fc2_done_o  out  1  FC2 phase complete
- err_valid_o  out  1  DLLP discarded (pulse)
- err_code_o  out  2  1=length, 2=CRC, 3=unknown type

Behaviour:
- Reset (sync, active-high): all outputs 0. s_axis_tready is 0 during rst and 1 otherwise. Byte counter, CRC register and all flags are cleared. A partial DLLP in flight at reset is lost silently, with no err pulse.
- Byte capture: bytes are captured on tvalid&tready. A 3-bit counter counts 0..5. The running CRC is updated per byte for bytes 0..3.
- States:
  - COLLECT → DROP: byte index 5 accepted without tlast. err_code 1 is reported one cycle later.
  - DROP → COLLECT: on the next tlast. Bytes are discarded while in DROP, with no further errors.
  - Early tlast: tlast on index 0..4 gives err_code 1 and the counter returns to 0.
- Decode: happens on tlast at index 5. All outputs are registered and valid exactly 1 cycle after the tlast beat, as 1-cycle pulses. Back-to-back DLLPs run with no bubbles.
- Type map:
  - 00 = Ack; 10 = Nak.
  - 20, 21, 23, 24, 30 → misc.
  - 4x/5x/6x = InitFC1 P/NP/Cpl.
  - Cx/Dx/Ex = InitFC2 P/NP/Cpl.
  - 8x/9x/Ax = UpdateFC P/NP/Cpl.
  - For FC types, type[3] must be 0.
  - Anything else → err_code 3.
- Priority: CRC error (when enabled) over unknown type. Exactly one of ack/fc/misc/err pulses per DLLP.
- Ack/Nak: byte1 and byte2[7:4] are ignored (reserved).
- Init tracking (FC DLLPs with fc_vc==INIT_VC only):
  - fc1 flags[2:0] set per class by InitFC1.
  - Any InitFC2 or UpdateFC sets all fc1 flags.
  - init_fc1_done_o = &flags.
  - init_fc2_done_o is set by the first InitFC2/UpdateFC received while init_fc1_done_o=1. If both events fall in the same cycle, fc1 is set first and fc2 is set in the following cycle.
  - link_up_i=0 clears flags and both done outputs the next cycle. Flags are sticky while link_up_i=1.
- Widths: FC values are zero-extended if FC_*_W exceeds the field width.

Optional Feature:
- Macro: DLLP_CRC_CHECK_EN.
- Defined:
  - CRC-16 per PCIe Base Spec §3.6.2.1: poly 100Bh, seed FFFFh, over bytes 0..3 LSb-first, result complemented and bit-reversed per byte.
  - The result is compared to {byte5, byte4}.
  - A mismatch gives err_code 2, and no event or init flag update occurs.
- Undefined:
  - No CRC logic.
  - Bytes 4..5 are counted for length checking but ignored.
  - err_code 2 is never produced.

Test Plan:
- Stream 00,00,0A,BC,crc → one cycle after tlast: ack_valid=1, ack_nak=0, ack_seq=ABC; no other pulses.
- Stream 40,3F,C5,55,crc, then 50,..., then 60,... (VC0), link_up=1 → fc_hdr=FF, fc_data=555, phase 0, class 0. init_fc1_done=1 after the third DLLP. A following C0 DLLP → init_fc2_done=1.
- DLLP 00,00,0F,FF with corrupted byte4 (CRC_EN defined) → err_code=2, no ack pulse. With the macro undefined → ack_valid=1, seq=FFF.
- tlast on byte 3 → err_code=1, then a valid Nak (10,00,00,05) → ack_nak=1, seq=005. 8 bytes without tlast, then tlast → a single err_code=1, next DLLP decodes normally.
- Type 70 → err_code=3. Type 41 (VC1) with INIT_VC=0 → fc_valid=1, fc_vc=1, init flags unchanged.
- init done=1, then link_up_i=0 for 1 cycle → both done bits 0 next cycle. Assert rst mid-DLLP → no pulses, next DLLP decodes correctly.

Source files
------------

// File: rtl/pcie_dllp_rx.sv
// pcie_dllp_rx: receive-side DLLP decoder for the PCIe data link layer.
// Collects 6-byte DLLPs from an 8-bit AXI stream, checks length and type,
// emits single-cycle Ack/Nak, FC, misc and error events, and tracks
// InitFC1/InitFC2 reception on INIT_VC for the DL_Init state machine.
// Optional build macro DLLP_CRC_CHECK_EN adds the DLLP CRC-16 check.
module pcie_dllp_rx #(
  parameter int unsigned INIT_VC   = 0,
  parameter int unsigned FC_HDR_W  = 8,
  parameter int unsigned FC_DATA_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 link_up_i,
  output logic                 ack_valid_o,
  output logic                 ack_nak_o,
  output logic [11:0]          ack_seq_o,
  output logic                 fc_valid_o,
  output logic [1:0]           fc_phase_o,
  output logic [1:0]           fc_class_o,
  output logic [2:0]           fc_vc_o,
  output logic [FC_HDR_W-1:0]  fc_hdr_o,
  output logic [FC_DATA_W-1:0] fc_data_o,
  output logic                 misc_valid_o,
  output logic [31:0]          misc_dllp_o,
  output logic                 init_fc1_done_o,
  output logic                 init_fc2_done_o,
  output logic                 err_valid_o,
  output logic [1:0]           err_code_o
);

  localparam int unsigned       IDX_W    = 3;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(5);
  localparam logic [1:0]        ERR_LEN  = 2'd1;
  localparam logic [1:0]        ERR_CRC  = 2'd2;
  localparam logic [1:0]        ERR_TYPE = 2'd3;

  typedef enum logic {ST_COLLECT, ST_DROP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       b0_q, b1_q, b2_q, b3_q;
  logic [2:0]       flags_q, flags_d;
  logic             fc2_pend_q, fc2_pend_d, fc2_set;
  logic             beat, done_c, crc_bad;
  logic             is_ack, is_misc, is_fc, fc_init_ev;
  logic [1:0]       dec_phase, dec_class;

  // Always ready outside reset; the decoder never back-pressures.
  assign s_axis_tready = ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign done_c        = beat && (state_q == ST_COLLECT) && (idx_q == LAST_IDX) && s_axis_tlast;

`ifdef DLLP_CRC_CHECK_EN
  logic [7:0]  b4_q;
  logic [15:0] crc_q;
  logic [15:0] crc_inv;

  // One byte of the DLLP CRC-16 (poly 100Bh), bits taken LSb first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h100B;
    end
    return c;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Transmitted CRC is complemented and bit-reversed per byte; byte5 is the current beat.
  assign crc_inv = ~crc_q;
  assign crc_bad = {s_axis_tdata, b4_q} != {bitrev8(crc_inv[7:0]), bitrev8(crc_inv[15:8])};

  // Running CRC over bytes 0..3 (seeded at byte 0) and capture of byte 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 16'h0000;
      b4_q  <= 8'h00;
    end else if (beat && (state_q == ST_COLLECT)) begin
      if (idx_q <= IDX_W'(3))
        crc_q <= crc16_byte((idx_q == IDX_W'(0)) ? 16'hFFFF : crc_q, s_axis_tdata);
      if (idx_q == IDX_W'(4))
        b4_q <= s_axis_tdata;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Type classification of the captured byte 0.
  always_comb begin
    is_ack    = (b0_q == 8'h00) || (b0_q == 8'h10);
    is_misc   = (b0_q == 8'h20) || (b0_q == 8'h21) || (b0_q == 8'h23) ||
                (b0_q == 8'h24) || (b0_q == 8'h30);
    is_fc     = 1'b0;
    dec_phase = 2'd0;
    dec_class = b0_q[5:4];
    if (!b0_q[3] && (b0_q[5:4] != 2'b11)) begin
      case (b0_q[7:6])
        2'b01:   begin is_fc = 1'b1; dec_phase = 2'd0; end
        2'b11:   begin is_fc = 1'b1; dec_phase = 2'd1; end
        2'b10:   begin is_fc = 1'b1; dec_phase = 2'd2; end
        default: begin is_fc = 1'b0; dec_phase = 2'd0; end
      endcase
    end
  end

  // Init-tracking next state; an FC2-type event that completes FC1 defers fc2 by one cycle.
  always_comb begin
    flags_d    = flags_q;
    fc2_pend_d = 1'b0;
    fc2_set    = fc2_pend_q & init_fc1_done_o;
    fc_init_ev = done_c && !crc_bad && is_fc && (b0_q[2:0] == 3'(INIT_VC));
    if (fc_init_ev) begin
      if (dec_phase == 2'd0) begin
        case (dec_class)
          2'd0:    flags_d[0] = 1'b1;
          2'd1:    flags_d[1] = 1'b1;
          default: flags_d[2] = 1'b1;
        endcase
      end else begin
        flags_d = 3'b111;
        if (init_fc1_done_o) fc2_set    = 1'b1;
        else                 fc2_pend_d = 1'b1;
      end
    end
  end

  // Byte collection, length checking, decode and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_COLLECT;
      idx_q           <= '0;
      b0_q            <= 8'h00;
      b1_q            <= 8'h00;
      b2_q            <= 8'h00;
      b3_q            <= 8'h00;
      flags_q         <= 3'b000;
      fc2_pend_q      <= 1'b0;
      ack_valid_o     <= 1'b0;
      ack_nak_o       <= 1'b0;
      ack_seq_o       <= '0;
      fc_valid_o      <= 1'b0;
      fc_phase_o      <= 2'd0;
      fc_class_o      <= 2'd0;
      fc_vc_o         <= 3'd0;
      fc_hdr_o        <= '0;
      fc_data_o       <= '0;
      misc_valid_o    <= 1'b0;
      misc_dllp_o     <= '0;
      init_fc1_done_o <= 1'b0;
      init_fc2_done_o <= 1'b0;
      err_valid_o     <= 1'b0;
      err_code_o      <= 2'd0;
    end else begin
      ack_valid_o  <= 1'b0;
      fc_valid_o   <= 1'b0;
      misc_valid_o <= 1'b0;
      err_valid_o  <= 1'b0;

      if (beat) begin
        case (state_q)
          ST_COLLECT: begin
            case (idx_q)
              IDX_W'(0): b0_q <= s_axis_tdata;
              IDX_W'(1): b1_q <= s_axis_tdata;
              IDX_W'(2): b2_q <= s_axis_tdata;
              IDX_W'(3): b3_q <= s_axis_tdata;
              default: ;
            endcase
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (!s_axis_tlast) begin
                state_q     <= ST_DROP;
                err_valid_o <= 1'b1;
                err_code_o  <= ERR_LEN;
              end else if (crc_bad) begin
                err_valid_o <= 1'b1;
                err_code_o  <= ERR_CRC;
              end else if (is_ack) begin
                ack_valid_o <= 1'b1;
                ack_nak_o   <= b0_q[4];
                ack_seq_o   <= {b2_q[3:0], b3_q};
              end else if (is_fc) begin
                fc_valid_o <= 1'b1;
                fc_phase_o <= dec_phase;
                fc_class_o <= dec_class;
                fc_vc_o    <= b0_q[2:0];
                fc_hdr_o   <= FC_HDR_W'({b1_q[5:0], b2_q[7:6]});
                fc_data_o  <= FC_DATA_W'({b2_q[3:0], b3_q});
              end else if (is_misc) begin
                misc_valid_o <= 1'b1;
                misc_dllp_o  <= {b3_q, b2_q, b1_q, b0_q};
              end else begin
                err_valid_o <= 1'b1;
                err_code_o  <= ERR_TYPE;
              end
            end else if (s_axis_tlast) begin
              idx_q       <= '0;
              err_valid_o <= 1'b1;
              err_code_o  <= ERR_LEN;
            end else begin
              idx_q <= IDX_W'(idx_q + IDX_W'(1));
            end
          end
          default: begin
            if (s_axis_tlast) state_q <= ST_COLLECT;
          end
        endcase
      end

      if (!link_up_i) begin
        flags_q         <= 3'b000;
        fc2_pend_q      <= 1'b0;
        init_fc1_done_o <= 1'b0;
        init_fc2_done_o <= 1'b0;
      end else begin
        flags_q         <= flags_d;
        fc2_pend_q      <= fc2_pend_d;
        init_fc1_done_o <= &flags_d;
        if (fc2_set) init_fc2_done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcie_dllp_rx.sv
// tb_pcie_dllp_rx: directed and randomized stimulus for pcie_dllp_rx,
// checked cycle by cycle against a byte-queue reference model.
module tb_pcie_dllp_rx;

  localparam int unsigned INIT_VC   = 0;
  localparam int unsigned FC_HDR_W  = 8;
  localparam int unsigned FC_DATA_W = 12;
`ifdef DLLP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic                 clk, rst;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic                 link_up_i;
  logic                 ack_valid_o, ack_nak_o;
  logic [11:0]          ack_seq_o;
  logic                 fc_valid_o;
  logic [1:0]           fc_phase_o, fc_class_o;
  logic [2:0]           fc_vc_o;
  logic [FC_HDR_W-1:0]  fc_hdr_o;
  logic [FC_DATA_W-1:0] fc_data_o;
  logic                 misc_valid_o;
  logic [31:0]          misc_dllp_o;
  logic                 init_fc1_done_o, init_fc2_done_o;
  logic                 err_valid_o;
  logic [1:0]           err_code_o;

  pcie_dllp_rx #(.INIT_VC(INIT_VC), .FC_HDR_W(FC_HDR_W), .FC_DATA_W(FC_DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .link_up_i(link_up_i),
    .ack_valid_o(ack_valid_o), .ack_nak_o(ack_nak_o), .ack_seq_o(ack_seq_o),
    .fc_valid_o(fc_valid_o), .fc_phase_o(fc_phase_o), .fc_class_o(fc_class_o),
    .fc_vc_o(fc_vc_o), .fc_hdr_o(fc_hdr_o), .fc_data_o(fc_data_o),
    .misc_valid_o(misc_valid_o), .misc_dllp_o(misc_dllp_o),
    .init_fc1_done_o(init_fc1_done_o), .init_fc2_done_o(init_fc2_done_o),
    .err_valid_o(err_valid_o), .err_code_o(err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_drop;
  bit [2:0]   m_flags;
  bit         m_fc1, m_fc2, m_fc2_req;
  int         e_kind;  // 0 none, 1 ack/nak, 2 fc, 3 misc, 4 err
  int         e_nak, e_seq, e_phase, e_class, e_vc, e_hdr, e_data, e_err;
  logic [31:0] e_misc;

  logic [7:0] misc_tab [5] = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h30};
  int         fc_hi_tab [9] = '{4, 5, 6, 12, 13, 14, 8, 9, 10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {byte5, byte4} for DLLP bytes 0..3 packed as {b3,b2,b1,b0}.
  function automatic logic [15:0] crc_field(input logic [31:0] msg);
    logic [15:0] r;
    logic [15:0] f;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      fb = r[15] ^ msg[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    r = ~r;
    for (int k = 0; k < 8; k++) begin
      f[k]     = r[15-k];
      f[8 + k] = r[7-k];
    end
    return f;
  endfunction

  // Classify a complete 6-byte DLLP held in the model queue.
  task automatic model_decode();
    int t, hi;
    logic [15:0] got;
    t   = int'(mq[0]);
    hi  = t / 16;
    got = {mq[5], mq[4]};
    if (CRC_EN && (got != crc_field({mq[3], mq[2], mq[1], mq[0]}))) begin
      e_kind = 4; e_err = 2;
    end else if (t == 8'h00 || t == 8'h10) begin
      e_kind = 1; e_nak = (t == 8'h10) ? 1 : 0;
      e_seq  = (int'(mq[2]) % 16) * 256 + int'(mq[3]);
    end else if (t == 8'h20 || t == 8'h21 || t == 8'h23 || t == 8'h24 || t == 8'h30) begin
      e_kind = 3; e_misc = {mq[3], mq[2], mq[1], mq[0]};
    end else if (((t / 8) % 2 == 0) && (hi inside {4, 5, 6, 8, 9, 10, 12, 13, 14})) begin
      e_kind  = 2;
      e_phase = (hi <= 6) ? 0 : ((hi >= 12) ? 1 : 2);
      e_class = hi % 4;
      e_vc    = t % 8;
      e_hdr   = (int'(mq[1]) % 64) * 4 + int'(mq[2]) / 64;
      e_data  = (int'(mq[2]) % 16) * 256 + int'(mq[3]);
    end else begin
      e_kind = 4; e_err = 3;
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_drop = 0; m_flags = 3'b000; m_fc1 = 0; m_fc2 = 0; m_fc2_req = 0;
  endtask

  // One clock: drive a beat (or idle), advance the model, compare all outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit l);
    bit fc2_ev, init_ev;
    bit new_fc2;
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
    @(posedge clk);
    #1;
    e_kind = 0;
    if (v) begin
      if (m_drop) begin
        if (l) m_drop = 0;
      end else begin
        mq.push_back(d);
        if (mq.size() == 6) begin
          if (l) model_decode();
          else begin e_kind = 4; e_err = 1; m_drop = 1; end
          mq.delete();
        end else if (l) begin
          e_kind = 4; e_err = 1; mq.delete();
        end
      end
    end
    init_ev = (e_kind == 2) && (e_vc == INIT_VC);
    fc2_ev  = init_ev && (e_phase != 0);
    if (!link_up_i) begin
      m_flags = 3'b000; m_fc1 = 0; m_fc2 = 0; m_fc2_req = 0;
    end else begin
      new_fc2   = m_fc2 || (m_fc1 && (fc2_ev || m_fc2_req));
      m_fc2_req = fc2_ev && !m_fc1;
      if (init_ev) begin
        if (e_phase == 0) m_flags[e_class] = 1'b1;
        else              m_flags = 3'b111;
      end
      m_fc1 = (m_flags == 3'b111);
      m_fc2 = new_fc2;
    end
    chk("tready", 32'(s_axis_tready), 32'd1);
    chk("ack_valid", 32'(ack_valid_o), 32'(e_kind == 1));
    chk("fc_valid", 32'(fc_valid_o), 32'(e_kind == 2));
    chk("misc_valid", 32'(misc_valid_o), 32'(e_kind == 3));
    chk("err_valid", 32'(err_valid_o), 32'(e_kind == 4));
    chk("init_fc1_done", 32'(init_fc1_done_o), 32'(m_fc1));
    chk("init_fc2_done", 32'(init_fc2_done_o), 32'(m_fc2));
    if (e_kind == 1) begin
      chk("ack_nak", 32'(ack_nak_o), 32'(e_nak));
      chk("ack_seq", 32'(ack_seq_o), 32'(e_seq));
    end
    if (e_kind == 2) begin
      chk("fc_phase", 32'(fc_phase_o), 32'(e_phase));
      chk("fc_class", 32'(fc_class_o), 32'(e_class));
      chk("fc_vc", 32'(fc_vc_o), 32'(e_vc));
      chk("fc_hdr", 32'(fc_hdr_o), 32'(e_hdr));
      chk("fc_data", 32'(fc_data_o), 32'(e_data));
    end
    if (e_kind == 3) chk("misc_dllp", misc_dllp_o, e_misc);
    if (e_kind == 4) chk("err_code", 32'(err_code_o), 32'(e_err));
  endtask

  // Well-formed DLLP with proper CRC bytes; optional corruption and idle gaps.
  task automatic send(input logic [7:0] b0, b1, b2, b3, input bit corrupt, input bit gaps);
    logic [7:0]  b [6];
    logic [15:0] c;
    c = crc_field({b3, b2, b1, b0});
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = c[7:0]; b[5] = c[15:8];
    if (corrupt) b[4] = b[4] ^ 8'h01;
    for (int i = 0; i < 6; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, b[i], i == 5);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      s_axis_tvalid = 1'($urandom); s_axis_tdata = 8'($urandom); s_axis_tlast = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_pulses", 32'({ack_valid_o, fc_valid_o, misc_valid_o, err_valid_o}), 32'd0);
      chk("rst_done", 32'({init_fc1_done_o, init_fc2_done_o}), 32'd0);
      chk("rst_err_code", 32'(err_code_o), 32'd0);
    end
    rst = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    model_clear();
    #1;
    chk("tready_after_rst", 32'(s_axis_tready), 32'd1);
  endtask

  function automatic logic [7:0] rand_type();
    logic [7:0] t;
    int hi;
    case ($urandom_range(0, 5))
      0: t = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h10;
      1: t = misc_tab[$urandom_range(0, 4)];
      2, 3: begin
        hi = fc_hi_tab[$urandom_range(0, 8)];
        t  = 8'(hi * 16) | (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 7)));
      end
      default: t = 8'($urandom);
    endcase
    return t;
  endfunction

  initial begin
    int n;
    rst = 1'b1; link_up_i = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    model_clear();
    do_reset(3);
    link_up_i = 1'b1;

    // Ack with sequence ABC
    send(8'h00, 8'h00, 8'h0A, 8'hBC, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // InitFC1 P/NP/Cpl on VC0, then InitFC2 P
    send(8'h40, 8'h3F, 8'hC5, 8'h55, 1'b0, 1'b0);
    send(8'h50, 8'h3F, 8'hC5, 8'h55, 1'b0, 1'b0);
    send(8'h60, 8'h3F, 8'hC5, 8'h55, 1'b0, 1'b0);
    chk("fc1_done_after_three", 32'(init_fc1_done_o), 32'd1);
    send(8'hC0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    chk("fc2_done_after_c0", 32'(init_fc2_done_o), 32'd1);

    // Corrupted CRC byte
    send(8'h00, 8'h00, 8'h0F, 8'hFF, 1'b1, 1'b0);

    // Early tlast on index 3, then a Nak
    step(1'b1, 8'h10, 1'b0); step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0); step(1'b1, 8'h05, 1'b1);
    send(8'h10, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);

    // Eight bytes without tlast, then tlast; then a normal DLLP
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'h00, 1'b1);
    send(8'h00, 8'h00, 8'h01, 8'h23, 1'b0, 1'b0);

    // Unknown type, link drop, FC on another VC
    send(8'h70, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    link_up_i = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    link_up_i = 1'b1;
    chk("link_drop_fc1", 32'(init_fc1_done_o), 32'd0);
    chk("link_drop_fc2", 32'(init_fc2_done_o), 32'd0);
    send(8'h41, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    send(8'h51, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    send(8'h61, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    chk("other_vc_no_fc1", 32'(init_fc1_done_o), 32'd0);

    // InitFC2 completing FC1 in one event defers fc2 by a cycle
    send(8'hD0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      link_up_i = ($urandom_range(0, 60) != 0);
      case ($urandom_range(0, 15))
        0: begin
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), i == n - 1);
        end
        1: begin
          n = $urandom_range(6, 9);
          for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0);
          step(1'b1, 8'($urandom), 1'b1);
        end
        2: send(rand_type(), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1);
        default: send(rand_type(), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      endcase
    end
    link_up_i = 1'b1;

    // Reset in the middle of a DLLP, then a clean DLLP
    step(1'b1, 8'h00, 1'b0); step(1'b1, 8'h00, 1'b0); step(1'b1, 8'h07, 1'b0);
    do_reset(2);
    send(8'h10, 8'h00, 8'h07, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
